alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//  Multi-cycle control stage directly upstream of the 16-bit ALU.
//  - Accepts an op request, collects one or two operands from the 16-bit data bus, drives the ALU's
//    in_1/in_2/select/enable/carry_in, captures result and flags, reports done.
//  - Owns the architectural accumulator and the carry/zero status flags; the ALU itself holds no state.
// PARAMETERS
//  WIDTH      16  datapath width; must match ALU operand width.
//  OP_W        3  opcode width; must match ALU select width.
// PORTS
//  clk           in   1      single clock, rising edge
//  reset         in   1      asynchronous, active-high
//  start         in   1      op request; sampled only in IDLE
//  op            in   3      opcode, captured with start
//  bus_in        in   WIDTH  operand word from bus
//  bus_valid     in   1      bus_in holds a valid operand this cycle
//  clear_flags   in   1      synchronous clear of carry_flag/zero_flag
//  busy          out  1      high in every state except IDLE
//  done          out  1      one-cycle pulse when result is latched
//  acc_out       out  WIDTH  accumulator (last ALU result)
//  carry_flag    out  1      latched ALU carry_out
//  zero_flag     out  1      latched ALU zero flag
//  alu_in_1      out  WIDTH  operand A to ALU
//  alu_in_2      out  WIDTH  operand B to ALU
//  alu_select    out  OP_W   opcode to ALU
//  alu_enable    out  1      ALU enable / bus drive
//  alu_carry_in  out  1      ALU carry input
//  alu_data      in   WIDTH  ALU result
//  alu_carry_out in   1      ALU carry flag
//  alu_zero      in   1      ALU zero flag
// BEHAVIOUR
//  - Reset value of every output and register is 0; state = IDLE. ALU bus is released while reset is high.
//  - States:
//    - IDLE: start=1 -> latch op -> LOAD_A. busy=0.
//    - LOAD_A: wait for bus_valid; on bus_valid, bus_in -> opA.
//      - Unary op (5 INV, 6 INC, 7 DEC) -> EXEC, with opB cleared to 0.
//      - Otherwise -> LOAD_B.
//    - LOAD_B: wait for bus_valid; on bus_valid, bus_in -> opB -> EXEC.
//    - EXEC: alu_enable=1 (rising edge triggers ALU evaluation) -> CAPTURE.
//    - CAPTURE: alu_enable stays 1; at clock edge alu_data -> acc_out, alu_carry_out -> carry_flag,
//      alu_zero -> zero_flag -> DONE.
//    - DONE: done=1 for exactly one cycle, alu_enable=0 -> IDLE.
//  - alu_in_1/alu_in_2/alu_select are registered from opA/opB/op and stable throughout EXEC and CAPTURE.
//  - Latency with bus_valid held high: binary op, start@0 -> done@5; unary op -> done@4.
//  - start while busy is ignored; no queueing. An unlisted op value cannot occur (3-bit, all 8 defined).
//  - clear_flags zeroes both flags next edge.
//    - If asserted in the same cycle as the CAPTURE edge, the capture wins.
//    - clear_flags does not affect acc_out.
//  - Arithmetic is done in the ALU only; carry_flag is the ALU's bit 16. Wrap-around (e.g. 0xFFFF+1)
//    yields acc=0, carry=1, zero=1.
//  - Asynchronous reset mid-operation aborts it: no done pulse, flags and acc return to 0.
// CONFIGURATION
//  - ALU_CARRY_CHAIN_EN defined: alu_carry_in = carry_flag during EXEC/CAPTURE, for multi-word adds.
//  - ALU_CARRY_CHAIN_EN not defined: alu_carry_in tied 0; ADD is a plain add.
// STRUCTURE
//  - Package alu_pkg: WIDTH/OP_W constants, opcode constants ALU_ADD=0 SUB=1 AND=2 OR=3 XOR=4 INV=5
//    INC=6 DEC=7, state encoding, is_unary() function.
//  - Sub-module alu_status_reg: acc_out, carry_flag, zero_flag with capture/clear priority.
// TESTING
//  - Reset asserted mid-LOAD_B:
//    - immediate release: alu_enable=0, busy=0, flags/acc=0;
//    - no done pulse;
//    - next op then runs normally.
//  - ADD 0x1234+0x0001, bus_valid high, carry_flag=0 -> done@5, acc=0x1235, carry=0, zero=0.
//  - ADD 0xFFFF+0x0001 -> acc=0x0000, carry=1, zero=1.
//    - Then, with ALU_CARRY_CHAIN_EN, ADD 0x0000+0x0000 -> acc=0x0001, carry=0, zero=0.
//    - Without ALU_CARRY_CHAIN_EN, the same second ADD -> acc=0x0000, zero=1.
//  - DEC 0x0001 (unary) -> done@4, opB=0, acc=0x0000, zero=1.
//    - bus_valid low 3 cycles in LOAD_A stretches done to @7.
//  - start pulsed during EXEC -> ignored, exactly one done.
//    - clear_flags coincident with the CAPTURE edge -> flags reflect the ALU result.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants, opcode encodings, FSM state type and opcode helpers for
// the ALU sequencer slice.
package alu_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned OP_W  = 3;

  // Opcodes understood by the downstream ALU (all 8 codes are defined)
  localparam logic [OP_W-1:0] ALU_ADD = 3'd0;
  localparam logic [OP_W-1:0] ALU_SUB = 3'd1;
  localparam logic [OP_W-1:0] ALU_AND = 3'd2;
  localparam logic [OP_W-1:0] ALU_OR  = 3'd3;
  localparam logic [OP_W-1:0] ALU_XOR = 3'd4;
  localparam logic [OP_W-1:0] ALU_INV = 3'd5;
  localparam logic [OP_W-1:0] ALU_INC = 3'd6;
  localparam logic [OP_W-1:0] ALU_DEC = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_A  = 3'd1,
    S_LOAD_B  = 3'd2,
    S_EXEC    = 3'd3,
    S_CAPTURE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  // Unary ops take only operand A; operand B is forced to zero
  function automatic logic is_unary(input logic [OP_W-1:0] op);
    return (op == ALU_INV) || (op == ALU_INC) || (op == ALU_DEC);
  endfunction

endpackage

// File: rtl/alu_status_reg.sv
// Architectural accumulator plus carry/zero status flags.
// A capture of the ALU result takes priority over a synchronous flag clear;
// the clear never touches the accumulator.
module alu_status_reg #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             capture,
  input  logic             clear_flags,
  input  logic [WIDTH-1:0] alu_data,
  input  logic             alu_carry_out,
  input  logic             alu_zero,
  output logic [WIDTH-1:0] acc_out,
  output logic             carry_flag,
  output logic             zero_flag
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;

  // Next-state selection: capture over clear over hold
  always_comb begin
    acc_d   = acc_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    if (capture) begin
      acc_d   = alu_data;
      carry_d = alu_carry_out;
      zero_d  = alu_zero;
    end else if (clear_flags) begin
      carry_d = 1'b0;
      zero_d  = 1'b0;
    end
  end

  // Status registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  assign acc_out    = acc_q;
  assign carry_flag = carry_q;
  assign zero_flag  = zero_q;

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle control stage in front of the 16-bit ALU: collects one or two
// operands from the bus, drives the ALU for EXEC/CAPTURE, latches the result
// and flags, and pulses done.
// Optional feature macro: ALU_CARRY_CHAIN_EN (feeds carry_flag back as the
// ALU carry input during EXEC/CAPTURE for multi-word adds).
module alu_sequencer #(
  parameter int unsigned WIDTH = alu_pkg::WIDTH,
  parameter int unsigned OP_W  = alu_pkg::OP_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             bus_valid,
  input  logic             clear_flags,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] acc_out,
  output logic             carry_flag,
  output logic             zero_flag,
  output logic [WIDTH-1:0] alu_in_1,
  output logic [WIDTH-1:0] alu_in_2,
  output logic [OP_W-1:0]  alu_select,
  output logic             alu_enable,
  output logic             alu_carry_in,
  input  logic [WIDTH-1:0] alu_data,
  input  logic             alu_carry_out,
  input  logic             alu_zero
);

  import alu_pkg::*;

  state_t           state_q, state_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] in1_q, in1_d;
  logic [WIDTH-1:0] in2_q, in2_d;
  logic [OP_W-1:0]  sel_q, sel_d;
  logic             capture;

  // Next-state, operand collection and ALU-input staging
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    sel_d   = sel_q;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          state_d = S_LOAD_A;
        end
      end
      S_LOAD_A: begin
        if (bus_valid) begin
          opa_d = bus_in;
          if (is_unary(op_q)) begin
            opb_d   = '0;
            state_d = S_EXEC;
          end else begin
            state_d = S_LOAD_B;
          end
        end
      end
      S_LOAD_B: begin
        if (bus_valid) begin
          opb_d   = bus_in;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        capture = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // ALU inputs are loaded on entry to EXEC from the operands being
    // committed this cycle, so they hold steady through EXEC and CAPTURE.
    if ((state_d == S_EXEC) && (state_q != S_EXEC)) begin
      in1_d = opa_d;
      in2_d = opb_d;
      sel_d = op_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      in1_q   <= '0;
      in2_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      sel_q   <= sel_d;
    end
  end

  // State-decoded status and ALU enable
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    alu_enable = 1'b0;
    if (state_q != S_IDLE) busy = 1'b1;
    if (state_q == S_DONE) done = 1'b1;
    if ((state_q == S_EXEC) || (state_q == S_CAPTURE)) alu_enable = 1'b1;
  end

  assign alu_in_1   = in1_q;
  assign alu_in_2   = in2_q;
  assign alu_select = sel_q;

`ifdef ALU_CARRY_CHAIN_EN
  assign alu_carry_in = alu_enable & carry_flag;
`else
  assign alu_carry_in = 1'b0;
`endif

  alu_status_reg #(.WIDTH(WIDTH)) u_status (
    .clk          (clk),
    .reset        (reset),
    .capture      (capture),
    .clear_flags  (clear_flags),
    .alu_data     (alu_data),
    .alu_carry_out(alu_carry_out),
    .alu_zero     (alu_zero),
    .acc_out      (acc_out),
    .carry_flag   (carry_flag),
    .zero_flag    (zero_flag)
  );

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a behavioural ALU stub answers the DUT's ALU port,
// a table of directed vectors, hand sequences for the multi-cycle corners and
// a randomized run against a reference model of acc/flags/latency.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, bus_valid, clear_flags;
  logic [2:0]  op;
  logic [15:0] bus_in;
  logic        busy, done, carry_flag, zero_flag;
  logic [15:0] acc_out, alu_in_1, alu_in_2, alu_data;
  logic [2:0]  alu_select;
  logic        alu_enable, alu_carry_in, alu_carry_out, alu_zero;
  logic [16:0] alu_res;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef ALU_CARRY_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif

  always #5 clk = ~clk;

  alu_sequencer #(.WIDTH(16), .OP_W(3)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .bus_in(bus_in),
    .bus_valid(bus_valid), .clear_flags(clear_flags), .busy(busy), .done(done),
    .acc_out(acc_out), .carry_flag(carry_flag), .zero_flag(zero_flag),
    .alu_in_1(alu_in_1), .alu_in_2(alu_in_2), .alu_select(alu_select),
    .alu_enable(alu_enable), .alu_carry_in(alu_carry_in), .alu_data(alu_data),
    .alu_carry_out(alu_carry_out), .alu_zero(alu_zero)
  );

  // Behavioural ALU: {carry, result} using plain integer arithmetic.
  // Carry input only affects ADD; SUB/DEC carry is the borrow (bit 16).
  function automatic logic [16:0] ref_alu(input logic [2:0] sel, input logic [15:0] a,
                                          input logic [15:0] b, input logic cin);
    int unsigned ua, ub, s;
    ua = a; ub = b;
    case (sel)
      3'd0:    s = ua + ub + (cin ? 1 : 0);
      3'd1:    s = ua - ub;
      3'd2:    s = ua & ub;
      3'd3:    s = ua | ub;
      3'd4:    s = ua ^ ub;
      3'd5:    s = (~ua) & 32'hFFFF;
      3'd6:    s = ua + 1;
      default: s = ua - 1;
    endcase
    return s[16:0];
  endfunction

  // ALU stub: only answers while enabled
  assign alu_res       = alu_enable ? ref_alu(alu_select, alu_in_1, alu_in_2, alu_carry_in) : 17'd0;
  assign alu_data      = alu_res[15:0];
  assign alu_carry_out = alu_res[16];
  assign alu_zero      = alu_enable && (alu_res[15:0] == 16'd0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one op. Cycle 0 is the cycle start is high; operand A is presented
  // after ga idle bus cycles, operand B after gb more. start is re-pulsed at
  // cycle poke_at and clear_flags asserted at cycle clr_at (-1 = never).
  task automatic run_op(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                        input int ga, input int gb, input int poke_at, input int clr_at,
                        output int lat, output int ndone, output logic [15:0] x1,
                        output logic [15:0] x2, output logic [2:0] xs, output bit stable);
    bit seen_en;
    bit unary;
    unary   = (o >= 3'd5);
    lat     = -1;
    ndone   = 0;
    seen_en = 1'b0;
    stable  = 1'b1;
    x1 = '0; x2 = '0; xs = '0;
    @(negedge clk);
    start = 1'b1; op = o; bus_valid = 1'b0; bus_in = 16'($urandom);
    clear_flags = (clr_at == 0);
    for (int t = 1; t < 60; t++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (lat < 0) lat = t;
      end
      if (alu_enable) begin
        if (!seen_en) begin
          x1 = alu_in_1; x2 = alu_in_2; xs = alu_select; seen_en = 1'b1;
        end else if (alu_in_1 !== x1 || alu_in_2 !== x2 || alu_select !== xs) begin
          stable = 1'b0;
        end
      end
      if (lat >= 0 && t >= lat + 3) break;
      start       = (t == poke_at);
      clear_flags = (t == clr_at);
      bus_valid   = 1'b0;
      bus_in      = 16'($urandom);
      if (t == ga + 1) begin
        bus_valid = 1'b1; bus_in = a;
      end else if (!unary && t == ga + 2 + gb) begin
        bus_valid = 1'b1; bus_in = b;
      end
    end
    start = 1'b0; clear_flags = 1'b0; bus_valid = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] acc;
    logic        c;
    logic        z;
    int          lat;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int          lat, nd, exp_lat;
    logic [15:0] x1, x2;
    logic [2:0]  xs;
    bit          st;
    logic [15:0] m_acc;
    logic        m_c, m_z;
    logic [16:0] r;

    tbl[0]  = '{3'd0, 16'h1234, 16'h0001, 16'h1235, 1'b0, 1'b0, 5};
    tbl[1]  = '{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 5};
    tbl[2]  = '{3'd1, 16'h0005, 16'h0007, 16'hFFFE, 1'b1, 1'b0, 5};
    tbl[3]  = '{3'd1, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1, 5};
    tbl[4]  = '{3'd2, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 5};
    tbl[5]  = '{3'd3, 16'hF000, 16'h000F, 16'hF00F, 1'b0, 1'b0, 5};
    tbl[6]  = '{3'd4, 16'hAAAA, 16'hAAAA, 16'h0000, 1'b0, 1'b1, 5};
    tbl[7]  = '{3'd5, 16'h00FF, 16'h1111, 16'hFF00, 1'b0, 1'b0, 4};
    tbl[8]  = '{3'd6, 16'hFFFF, 16'h2222, 16'h0000, 1'b1, 1'b1, 4};
    tbl[9]  = '{3'd7, 16'h0001, 16'h3333, 16'h0000, 1'b0, 1'b1, 4};
    tbl[10] = '{3'd7, 16'h0000, 16'h4444, 16'hFFFF, 1'b1, 1'b0, 4};

    reset = 1'b1; start = 1'b0; op = '0; bus_in = '0; bus_valid = 1'b0; clear_flags = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_acc", acc_out, 0);
    chk("rst_flags", {carry_flag, zero_flag}, 0);
    chk("rst_alu_bus", {alu_enable, alu_carry_in, alu_select, alu_in_1, alu_in_2}, 0);
    reset = 1'b0;

    // Directed table; flags cleared alongside start so no carry is chained in
    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, 0, 0, -1, 0, lat, nd, x1, x2, xs, st);
      chk($sformatf("v%0d_acc", i), acc_out, tbl[i].acc);
      chk($sformatf("v%0d_cz", i), {carry_flag, zero_flag}, {tbl[i].c, tbl[i].z});
      chk($sformatf("v%0d_lat", i), lat, tbl[i].lat);
      chk($sformatf("v%0d_ndone", i), nd, 1);
      chk($sformatf("v%0d_alu_in", i), {xs, x1}, {tbl[i].op, tbl[i].a});
      chk($sformatf("v%0d_in2", i), x2, (tbl[i].op >= 3'd5) ? 16'h0 : tbl[i].b);
      chk($sformatf("v%0d_stable", i), st, 1);
      chk($sformatf("v%0d_busy", i), busy, 0);
    end

    // Idle clear_flags zeroes flags, leaves acc (acc=FFFF, carry=1 from last vector)
    @(negedge clk); clear_flags = 1'b1;
    @(negedge clk); clear_flags = 1'b0;
    chk("clr_flags", {carry_flag, zero_flag}, 0);
    chk("clr_acc", acc_out, 16'hFFFF);

    // Wrap-around then a chained (or plain) zero add
    run_op(3'd0, 16'hFFFF, 16'h0001, 0, 0, -1, -1, lat, nd, x1, x2, xs, st);
    chk("wrap_acc", acc_out, 16'h0000);
    chk("wrap_cz", {carry_flag, zero_flag}, 2'b11);
    run_op(3'd0, 16'h0000, 16'h0000, 0, 0, -1, -1, lat, nd, x1, x2, xs, st);
    chk("chain_acc", acc_out, CHAIN ? 16'h0001 : 16'h0000);
    chk("chain_cz", {carry_flag, zero_flag}, CHAIN ? 2'b00 : 2'b01);

    // DEC with operand A delayed 3 cycles
    run_op(3'd7, 16'h0001, 16'hBEEF, 3, 0, -1, -1, lat, nd, x1, x2, xs, st);
    chk("dec_gap_lat", lat, 7);
    chk("dec_gap_in2", x2, 0);
    chk("dec_gap_acc", acc_out, 0);
    chk("dec_gap_z", zero_flag, 1);

    // start re-pulsed in EXEC, clear_flags on the CAPTURE edge (carry is 0 here)
    run_op(3'd0, 16'hFFFF, 16'h0001, 0, 0, 3, 4, lat, nd, x1, x2, xs, st);
    chk("poke_ndone", nd, 1);
    chk("poke_lat", lat, 5);
    chk("poke_cz", {carry_flag, zero_flag}, 2'b11);
    chk("poke_busy", busy, 0);

    // Async reset in the middle of LOAD_B
    run_op(3'd0, 16'h1234, 16'h0001, 0, 0, -1, 0, lat, nd, x1, x2, xs, st);
    @(negedge clk); start = 1'b1; op = 3'd0;
    @(negedge clk); start = 1'b0; bus_valid = 1'b1; bus_in = 16'h0005;
    @(negedge clk); bus_valid = 1'b0;
    chk("mid_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_enable", alu_enable, 0);
    chk("arst_busy", busy, 0);
    chk("arst_acc_flags", {acc_out, carry_flag, zero_flag}, 0);
    @(negedge clk); reset = 1'b0;
    nd = 0;
    bus_valid = 1'b1;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (done) nd++;
    end
    bus_valid = 1'b0;
    chk("arst_no_done", nd, 0);
    run_op(3'd0, 16'h0002, 16'h0003, 0, 0, -1, -1, lat, nd, x1, x2, xs, st);
    chk("post_rst_acc", acc_out, 16'h0005);
    chk("post_rst_lat", lat, 5);

    // Randomized ops against the reference model
    m_acc = acc_out; m_c = carry_flag; m_z = zero_flag;
    for (int k = 0; k < 40; k++) begin
      logic [2:0]  o;
      logic [15:0] a, b;
      int ga, gb, clr;
      o   = 3'($urandom_range(0, 7));
      a   = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      b   = ($urandom_range(0, 3) == 0) ? 16'h0001 : 16'($urandom);
      ga  = $urandom_range(0, 2);
      gb  = $urandom_range(0, 2);
      clr = ($urandom_range(0, 3) == 0) ? 0 : -1;
      if (clr == 0) begin m_c = 1'b0; m_z = 1'b0; end
      r       = ref_alu(o, a, (o >= 3'd5) ? 16'h0 : b, CHAIN ? m_c : 1'b0);
      m_acc   = r[15:0];
      m_c     = r[16];
      m_z     = (r[15:0] == 16'h0);
      exp_lat = ga + 1 + ((o >= 3'd5) ? 0 : gb + 1) + 3;
      run_op(o, a, b, ga, gb, -1, clr, lat, nd, x1, x2, xs, st);
      chk($sformatf("r%0d_acc", k), acc_out, m_acc);
      chk($sformatf("r%0d_cz", k), {carry_flag, zero_flag}, {m_c, m_z});
      chk($sformatf("r%0d_lat", k), lat, exp_lat);
      chk($sformatf("r%0d_ndone", k), nd, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
